// File: rtl/seq_pkg.sv
// seq_pkg: shared constants, instruction classes and run modes for the sequencer.
package seq_pkg;
  localparam int NUM_CYCLES_DEF = 24;
  localparam int CLASS_W_DEF = 4;
  localparam logic [4:0] LAST_8 = 5'd8;
  localparam logic [4:0] LAST_12 = 5'd12;
  localparam logic [4:0] LAST_14 = 5'd14;
  localparam logic [4:0] LAST_24 = 5'd24;
  typedef enum logic [3:0] {
    CLS_MOV8  = 4'b0000,
    CLS_ALU   = 4'b1000,
    CLS_SETAB = 4'b0100,
    CLS_LDST  = 4'b1001,
    CLS_MOV16 = 4'b1010,
    CLS_INCXY = 4'b1011,
    CLS_GOTO  = 4'b1100
  } class_e;
  typedef enum logic [2:0] {
    M_IDLE       = 3'd0,
    M_RUN        = 3'd1,
    M_STEP_INSTR = 3'd2,
    M_STEP_CYCLE = 3'd3,
    M_HALTED     = 3'd4
  } mode_e;
  function automatic logic class_known(input logic [3:0] c);
    return c == CLS_MOV8 || c == CLS_ALU || c == CLS_SETAB || c == CLS_LDST ||
           c == CLS_MOV16 || c == CLS_INCXY || c == CLS_GOTO;
  endfunction
  function automatic logic [4:0] class_len(input logic [3:0] c);
    return (c == CLS_LDST || c == CLS_MOV16) ? LAST_12 :
           c == CLS_INCXY ? LAST_14 :
           c == CLS_GOTO ? LAST_24 : LAST_8;
  endfunction
endpackage

// File: rtl/seq_cycle_chain.sv
// seq_cycle_chain: one-hot timing chain that shifts on adv and reloads cycle 1 on wrap.
module seq_cycle_chain #(
  parameter int N = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         adv_i,
  input  logic         wrap_i,
  output logic [N-1:0] state_o
);
  localparam logic [N-1:0] FIRST = {{(N-1){1'b0}}, 1'b1};
  logic [N-1:0] state_q, state_d;
  always_comb state_d = !adv_i ? state_q : wrap_i ? FIRST : {state_q[N-2:0], 1'b0};
  always_ff @(posedge clock) begin
    if (reset) state_q <= FIRST;
    else state_q <= state_d;
  end
  assign state_o = state_q;
endmodule

// File: rtl/seq_run_control.sv
// seq_run_control: run/stop/step mode FSM gating the instruction timing chain,
// with class latch, pending stop and front-panel status flags.
module seq_run_control
  import seq_pkg::*;
#(
  parameter int NUM_CYCLES = NUM_CYCLES_DEF,
  parameter int CLASS_W = CLASS_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_req,
  input  logic                  stop_req,
  input  logic                  step_instr,
  input  logic                  step_cycle,
  input  logic [CLASS_W-1:0]    instruction_bits,
  input  logic                  halt_decoded,
  output logic [NUM_CYCLES-1:0] cycle_state,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done,
  output logic                  illegal_class
);
  mode_e mode_q, mode_d, wrap_mode, req_mode;
  logic [CLASS_W-1:0] class_q, class_d;
  logic stop_q, stop_d, illegal_q, illegal_d, done_q, done_d;
  logic running_q, running_d, halted_q, halted_d;
  logic adv, last, wrap_ev, in_run;
  seq_cycle_chain #(.N(NUM_CYCLES)) u_chain (
    .clock  (clock),
    .reset  (reset),
    .adv_i  (adv),
    .wrap_i (last),
    .state_o(cycle_state)
  );
  // Cycle-8 exit looks at live decode; later exits rely on the class latched at cycle 8.
  always_comb begin
    adv = mode_q == M_RUN || mode_q == M_STEP_INSTR || mode_q == M_STEP_CYCLE;
    in_run = mode_q == M_RUN || mode_q == M_STEP_INSTR;
    last = (cycle_state[7] && class_len(instruction_bits) == LAST_8) ||
           (cycle_state[11] && class_len(class_q) == LAST_12) ||
           (cycle_state[13] && class_len(class_q) == LAST_14) ||
           cycle_state[23];
    wrap_ev = adv && last;
    class_d = (adv && cycle_state[7]) ? instruction_bits : class_q;
    illegal_d = illegal_q || (adv && cycle_state[7] && !class_known(instruction_bits));
    done_d = wrap_ev;
    stop_d = wrap_ev ? 1'b0 : stop_q || (stop_req && in_run);
    wrap_mode = halt_decoded ? M_HALTED :
                (mode_q == M_STEP_INSTR || stop_q || stop_req) ? M_IDLE : M_RUN;
    req_mode = run_req ? M_RUN : step_instr ? M_STEP_INSTR :
               (step_cycle && mode_q == M_IDLE) ? M_STEP_CYCLE : mode_q;
    mode_d = (mode_q == M_IDLE || mode_q == M_HALTED) ? req_mode :
             mode_q == M_STEP_CYCLE ? M_IDLE :
             wrap_ev ? wrap_mode : mode_q;
    running_d = mode_d == M_RUN || mode_d == M_STEP_INSTR;
    halted_d = mode_d == M_HALTED;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= M_IDLE;
      class_q <= '0;
      stop_q <= 1'b0;
      illegal_q <= 1'b0;
      done_q <= 1'b0;
      running_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      class_q <= class_d;
      stop_q <= stop_d;
      illegal_q <= illegal_d;
      done_q <= done_d;
      running_q <= running_d;
      halted_q <= halted_d;
    end
  end
  assign running = running_q;
  assign halted = halted_q;
  assign instr_done = done_q;
  assign illegal_class = illegal_q;
endmodule
